// File: rtl/ps2_mouse_cursor.sv
// ps2_mouse_cursor: decodes standard 3-byte PS/2 mouse packets and tracks a clamped
// screen-space cursor.
//
// Ports:
//   CLOCK_50   system clock
//   resetn     asynchronous active-low reset
//   enable     1: movement applied; 0: x/y frozen (packets still parsed)
//   recenter   synchronous; loads X_INIT/Y_INIT into the cursor
//   rx_data    received PS/2 byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   x, y       cursor position, clamped to [0, X_MAX] / [0, Y_MAX]
//   buttons    button levels: [0] left, [1] right, [2] middle
//   click      one-cycle pulse per rising button edge, only after a commit
//   pkt_valid  one-cycle pulse per committed packet
//   sync_err   one-cycle pulse on a discarded header byte or an inter-byte timeout
//   state      packet FSM state (0 WAIT_B0, 1 WAIT_B1, 2 WAIT_B2)
module ps2_mouse_cursor #(
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned X_MAX       = 319,
  parameter int unsigned Y_MAX       = 239,
  parameter int unsigned X_INIT      = 160,
  parameter int unsigned Y_INIT      = 120,
  parameter int unsigned SHIFT       = 0,
  parameter bit          INVERT_Y    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           enable,
  input  logic           recenter,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     buttons,
  output logic [2:0]     click,
  output logic           pkt_valid,
  output logic           sync_err,
  output logic [1:0]     state
);

  // Two guard bits: one for the sign, one so MAX + 255 cannot wrap.
  localparam int unsigned W    = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic signed [W-1:0] XMaxS = W'(X_MAX);
  localparam logic signed [W-1:0] YMaxS = W'(Y_MAX);

  typedef enum logic [1:0] {
    StWaitB0 = 2'd0,
    StWaitB1 = 2'd1,
    StWaitB2 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Header byte without the always-one bit 3: {yovf, xovf, ysign, xsign, btn[2:0]}.
  logic [6:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic [2:0]      click_q, click_d;
  logic            pkt_valid_q;
  logic            sync_err_q, sync_err_d;
  logic            commit;

  // Packet framing and inter-byte timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    b0_d       = b0_q;
    b1_d       = b1_q;
    commit     = 1'b0;
    sync_err_d = 1'b0;
    unique case (state_q)
      StWaitB0: begin
        if (rx_valid) begin
          if (rx_data[3]) begin
            b0_d    = {rx_data[7:4], rx_data[2:0]};
            state_d = StWaitB1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      StWaitB1, StWaitB2: begin
        if (rx_valid) begin
          // A byte arriving on the expiry cycle still wins.
          if (state_q == StWaitB1) begin
            b1_d    = rx_data;
            state_d = StWaitB2;
          end else begin
            commit  = 1'b1;
            state_d = StWaitB0;
          end
        end else if (cnt_q == CntLast) begin
          state_d    = StWaitB0;
          sync_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StWaitB0;
    endcase
  end

  // Movement datapath; byte2 is consumed straight from rx_data on the commit edge.
  logic signed [8:0]   dx9, dy9, dx_sh, dy_sh;
  logic signed [W-1:0] dx_ext, dy_ext, x_sum, y_sum;
  logic [X_W-1:0]      x_clamp;
  logic [Y_W-1:0]      y_clamp;

  always_comb begin
    dx9    = b0_q[5] ? 9'sd0 : $signed({b0_q[3], b1_q});
    dy9    = b0_q[6] ? 9'sd0 : $signed({b0_q[4], rx_data});
    dx_sh  = dx9 >>> SHIFT;
    dy_sh  = dy9 >>> SHIFT;
    dx_ext = W'(dx_sh);
    dy_ext = W'(dy_sh);
    x_sum  = $signed(W'(x_q)) + dx_ext;
    if (INVERT_Y) begin
      y_sum = $signed(W'(y_q)) - dy_ext;
    end else begin
      y_sum = $signed(W'(y_q)) + dy_ext;
    end

    if (x_sum[W-1]) begin
      x_clamp = '0;
    end else if (x_sum > XMaxS) begin
      x_clamp = X_W'(X_MAX);
    end else begin
      x_clamp = x_sum[X_W-1:0];
    end

    if (y_sum[W-1]) begin
      y_clamp = '0;
    end else if (y_sum > YMaxS) begin
      y_clamp = Y_W'(Y_MAX);
    end else begin
      y_clamp = y_sum[Y_W-1:0];
    end
  end

  // Recenter outranks a coincident commit's movement but not its buttons.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    click_d = 3'b000;
    if (recenter) begin
      x_d = X_W'(X_INIT);
      y_d = Y_W'(Y_INIT);
    end else if (commit && enable) begin
      x_d = x_clamp;
      y_d = y_clamp;
    end
    if (commit) begin
      btn_d   = b0_q[2:0];
      click_d = b0_q[2:0] & ~btn_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StWaitB0;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      x_q         <= X_W'(X_INIT);
      y_q         <= Y_W'(Y_INIT);
      btn_q       <= '0;
      click_q     <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      btn_q       <= btn_d;
      click_q     <= click_d;
      pkt_valid_q <= commit;
      sync_err_q  <= sync_err_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign buttons   = btn_q;
  assign click     = click_q;
  assign pkt_valid = pkt_valid_q;
  assign sync_err  = sync_err_q;
  assign state     = state_q;

endmodule
